// File: rtl/stack_ctrl_pkg.sv
// ============================================================================
// Module : stack_ctrl_pkg
// Desc   : Op codes, FSM states and op-class helpers shared by the stack sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_INC  = 3'd4,
    ST_PCLD = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  // PUSH and CALL both pre-decrement SP and write memory.
  function automatic logic is_write_op(input op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

  function automatic logic loads_pc(input op_e op);
    return (op == OP_CALL) || (op == OP_RET);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_bounds_chk.sv
// ============================================================================
// Module : stack_bounds_chk
// Desc   : Combinational compare of the SP address bus against empty/limit bounds.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stack_bounds_chk
  import stack_ctrl_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] STACK_BASE  = 16'h0000,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 16'hFF00
) (
  input  logic [DATA_W-1:0] sp_addr,
  output logic              at_base,
  output logic              at_limit
);

  assign at_base  = (sp_addr == STACK_BASE);
  assign at_limit = (sp_addr == STACK_LIMIT);

endmodule

`default_nettype wire

// File: rtl/stack_ctrl.sv
// ============================================================================
// Module : stack_ctrl
// Desc   : PUSH/POP/CALL/RET sequencer for SP strobes, memory port and PC load.
//          Optional bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] STACK_BASE  = 16'h0000,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] op_data,
  input  logic [DATA_W-1:0] pc_in,
  output logic              op_ready,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] pop_data,
  output logic              sp_inc,
  output logic              sp_dec,
  output logic              sp_read_abus,
  input  logic [DATA_W-1:0] sp_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_load_val
);

  state_e            state;
  op_e               op_q;
  op_e               op_in;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] pop_q;
  logic [DATA_W-1:0] pcval_q;
  logic              fault_q;
  logic              at_base;
  logic              at_limit;

  assign op_in = op_e'(op_code);

`ifdef STACK_BOUNDS_CHECK_EN
  stack_bounds_chk #(
    .DATA_W      (DATA_W),
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_bounds (
    .sp_addr  (sp_addr),
    .at_base  (at_base),
    .at_limit (at_limit)
  );
`else
  logic unused_bounds;
  assign at_base       = 1'b0;
  assign at_limit      = 1'b0;
  assign unused_bounds = &{1'b0, sp_addr, STACK_BASE, STACK_LIMIT};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_PUSH;
      wdata_q <= '0;
      pop_q   <= '0;
      pcval_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          fault_q <= 1'b0;
          if (op_valid) begin
            op_q    <= op_in;
            pcval_q <= op_data;
            if (is_write_op(op_in)) begin
              wdata_q <= (op_in == OP_CALL) ? pc_in : op_data;
              state   <= ST_DEC;
            end else begin
              state   <= ST_RD;
            end
          end
        end
        ST_DEC: begin
          if (at_limit) begin
            fault_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            state   <= ST_WR;
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            state <= loads_pc(op_q) ? ST_PCLD : ST_DONE;
          end
        end
        ST_RD: begin
          // An empty-stack hit takes priority; the read strobe is never raised then.
          if (at_base) begin
            fault_q <= 1'b1;
            state   <= ST_DONE;
          end else if (mem_ack) begin
            pop_q <= mem_rdata;
            if (op_q == OP_RET) begin
              pcval_q <= mem_rdata;
            end
            state <= ST_INC;
          end
        end
        ST_INC:  state <= loads_pc(op_q) ? ST_PCLD : ST_DONE;
        ST_PCLD: state <= ST_DONE;
        ST_DONE: begin
          fault_q <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register.
  assign op_ready     = (state == ST_IDLE);
  assign done         = (state == ST_DONE);
  assign fault        = fault_q;
  assign sp_read_abus = (state != ST_IDLE);
  assign sp_dec       = (state == ST_DEC) && !at_limit;
  assign mem_wr       = (state == ST_WR);
  assign mem_rd       = (state == ST_RD) && !at_base;
  assign sp_inc       = (state == ST_INC);
  assign pc_load      = (state == ST_PCLD);
  assign mem_wdata    = wdata_q;
  assign pop_data     = pop_q;
  assign pc_load_val  = pcval_q;

  a_sp_excl  : assert property (@(posedge clk) disable iff (reset) !(sp_inc && sp_dec));
  a_mem_excl : assert property (@(posedge clk) disable iff (reset) !(mem_rd && mem_wr));

endmodule

`default_nettype wire

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus random ops against a stack/memory model.
`default_nettype none

module tb_stack_ctrl;

  localparam int          W     = 16;
  localparam logic [15:0] BASE  = 16'h0000;
  localparam logic [15:0] LIMIT = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [15:0] op_data, pc_in;
  logic        op_ready, done, fault;
  logic [15:0] pop_data;
  logic        sp_inc, sp_dec, sp_read_abus;
  logic [15:0] sp_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        pc_load;
  logic [15:0] pc_load_val;

  always #5 clk = ~clk;

  stack_ctrl #(.DATA_W(W), .STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_data(op_data),
    .pc_in(pc_in), .op_ready(op_ready), .done(done), .fault(fault), .pop_data(pop_data),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_read_abus(sp_read_abus), .sp_addr(sp_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pc_load(pc_load), .pc_load_val(pc_load_val)
  );

  // Environment: SP register and memory with programmable ack wait states.
  logic [15:0] sp;
  logic [15:0] env_mem [0:65535] = '{default: 16'h0000};
  int          wcnt = 0;
  int          ack_waits;
  logic        sp_load;
  logic [15:0] sp_load_val;

  assign sp_addr   = sp;
  assign mem_ack   = (mem_rd || mem_wr) && (wcnt >= ack_waits);
  assign mem_rdata = env_mem[sp];

  always @(posedge clk) begin
    if (sp_load)     sp <= sp_load_val;
    else if (sp_dec) sp <= sp - 16'd1;
    else if (sp_inc) sp <= sp + 16'd1;
    if (mem_wr && mem_ack) env_mem[sp] <= mem_wdata;
    if ((mem_rd || mem_wr) && !mem_ack) wcnt <= wcnt + 1;
    else                                wcnt <= 0;
  end

  // Reference model: plain stack semantics.
  logic [15:0] m_mem [0:65535] = '{default: 16'h0000};
  logic [15:0] m_sp;
  logic [15:0] m_pop;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %h want %h", name, got, want);
    else n_pass++;
  endtask

  task automatic do_op(input logic [1:0] code, input logic [15:0] data, input logic [15:0] pcv,
                       input int waits, input string name);
    logic        is_wr, is_pc, exp_fault, got_done, seen_fault;
    logic        bad_wdata, bad_abus, bad_excl;
    int          exp_lat, cyc, n_dec, n_inc, n_rd, n_wr, n_pcld;
    logic [15:0] exp_wdata, exp_pcval, seen_pcval;
    is_wr = (code == 2'b00) || (code == 2'b10);
    is_pc = code[1];
    exp_fault = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
    exp_fault = is_wr ? (m_sp == LIMIT) : (m_sp == BASE);
`endif
    exp_wdata = 16'h0; exp_pcval = 16'h0;
    if (exp_fault) begin
      exp_lat = 2;
    end else begin
      exp_lat = (is_pc ? 4 : 3) + waits;
      if (is_wr) begin
        m_sp           = m_sp - 16'd1;
        exp_wdata      = (code == 2'b10) ? pcv : data;
        m_mem[m_sp]    = exp_wdata;
        exp_pcval      = data;
      end else begin
        m_pop     = m_mem[m_sp];
        m_sp      = m_sp + 16'd1;
        exp_pcval = m_pop;
      end
    end

    ack_waits = waits;
    @(negedge clk);
    chk({name, " ready"}, {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1; op_code = code; op_data = data; pc_in = pcv;
    @(negedge clk);
    op_valid = 1'b0;
    cyc = 0; got_done = 0; seen_fault = 0; seen_pcval = 16'h0;
    n_dec = 0; n_inc = 0; n_rd = 0; n_wr = 0; n_pcld = 0;
    bad_wdata = 0; bad_abus = 0; bad_excl = 0;
    while (!got_done && cyc < 40) begin
      cyc++;
      if (sp_dec) n_dec++;
      if (sp_inc) n_inc++;
      if (mem_rd) n_rd++;
      if (mem_wr) begin
        n_wr++;
        if (mem_wdata !== exp_wdata) bad_wdata = 1;
      end
      if (pc_load) begin n_pcld++; seen_pcval = pc_load_val; end
      if (sp_read_abus !== 1'b1 || op_ready !== 1'b0) bad_abus = 1;
      if ((sp_inc && sp_dec) || (mem_rd && mem_wr)) bad_excl = 1;
      if (done) begin got_done = 1; seen_fault = fault; end
      else @(negedge clk);
    end
    chk({name, " latency"}, got_done ? cyc : 999, exp_lat);
    chk({name, " sp_dec"}, n_dec, (!exp_fault && is_wr) ? 1 : 0);
    chk({name, " sp_inc"}, n_inc, (!exp_fault && !is_wr) ? 1 : 0);
    chk({name, " mem_rd cycles"}, n_rd, (!exp_fault && !is_wr) ? 1 + waits : 0);
    chk({name, " mem_wr cycles"}, n_wr, (!exp_fault && is_wr) ? 1 + waits : 0);
    chk({name, " pc_load"}, n_pcld, (!exp_fault && is_pc) ? 1 : 0);
    if (!exp_fault && is_pc) chk({name, " pc_load_val"}, {16'd0, seen_pcval}, {16'd0, exp_pcval});
    chk({name, " fault"}, {31'd0, seen_fault}, {31'd0, exp_fault});
    chk({name, " pop_data"}, {16'd0, pop_data}, {16'd0, m_pop});
    chk({name, " sp"}, {16'd0, sp}, {16'd0, m_sp});
    if (!exp_fault && is_wr) chk({name, " mem"}, {16'd0, env_mem[m_sp]}, {16'd0, m_mem[m_sp]});
    chk({name, " wdata/abus/excl"}, {29'd0, bad_wdata, bad_abus, bad_excl}, 32'd0);
  endtask

  task automatic set_sp(input logic [15:0] v);
    @(negedge clk);
    sp_load = 1'b1; sp_load_val = v;
    @(negedge clk);
    sp_load = 1'b0;
    m_sp = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; sp_load = 1'b1; sp_load_val = BASE;
    repeat (3) @(negedge clk);
    reset = 1'b0; sp_load = 1'b0;
    m_sp = BASE; m_pop = 16'h0;
    @(negedge clk);
    chk("reset op_ready", {31'd0, op_ready}, 32'd1);
    chk("reset done/fault", {30'd0, done, fault}, 32'd0);
    chk("reset strobes", {26'd0, sp_inc, sp_dec, sp_read_abus, mem_rd, mem_wr, pc_load}, 32'd0);
    chk("reset pop_data", {16'd0, pop_data}, 32'd0);
    chk("reset mem_wdata", {16'd0, mem_wdata}, 32'd0);
  endtask

  task automatic test_push();
    do_op(2'b00, 16'hBEEF, 16'h0, 0, "push");
    chk("push sp FFFF", {16'd0, sp}, 32'h0000_FFFF);
    chk("push mem[FFFF]", {16'd0, env_mem[16'hFFFF]}, 32'h0000_BEEF);
  endtask

  task automatic test_pop();
    do_op(2'b01, 16'h0, 16'h0, 2, "pop");
    chk("pop value BEEF", {16'd0, pop_data}, 32'h0000_BEEF);
    chk("pop sp 0", {16'd0, sp}, 32'h0);
  endtask

  task automatic test_call_ret();
    do_op(2'b10, 16'h4000, 16'h0102, 0, "call");
    chk("call mem[FFFF]", {16'd0, env_mem[16'hFFFF]}, 32'h0000_0102);
    do_op(2'b11, 16'h0, 16'h0, 1, "ret");
    chk("ret pc_load_val", {16'd0, pc_load_val}, 32'h0000_0102);
    chk("ret sp restored", {16'd0, sp}, 32'h0);
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] sp_before;
    ack_waits = 1000;
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b00; op_data = 16'h1234; pc_in = 16'h0;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid in WR", {31'd0, mem_wr}, 32'd1);
    sp_before = sp;
    m_sp = m_sp - 16'd1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_pop = 16'h0;
    chk("rst_mid strobes", {26'd0, sp_inc, sp_dec, sp_read_abus, mem_rd, mem_wr, pc_load}, 32'd0);
    chk("rst_mid op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_mid sp held", {16'd0, sp}, {16'd0, sp_before});
    chk("rst_mid sp model", {16'd0, sp}, {16'd0, m_sp});
    chk("rst_mid no write", {16'd0, env_mem[m_sp]}, {16'd0, m_mem[m_sp]});
    ack_waits = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    int dones, done1, acc2;
    a = 16'($urandom); b = 16'($urandom);
    ack_waits = 0; dones = 0; done1 = -1; acc2 = -1;
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b00; op_data = a;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      if (cyc == 1) op_data = b;
      if (acc2 >= 0) op_valid = 1'b0;
      if (done) begin dones++; if (dones == 1) done1 = cyc; end
      if (op_valid && op_ready && acc2 < 0) acc2 = cyc;
    end
    m_sp = m_sp - 16'd1; m_mem[m_sp] = a;
    m_sp = m_sp - 16'd1; m_mem[m_sp] = b;
    chk("b2b done count", dones, 2);
    chk("b2b second accept", acc2, 4);
    chk("b2b accept after done", acc2, done1 + 1);
    chk("b2b sp", {16'd0, sp}, {16'd0, m_sp});
    chk("b2b mem first", {16'd0, env_mem[m_sp + 16'd1]}, {16'd0, a});
    chk("b2b mem second", {16'd0, env_mem[m_sp]}, {16'd0, b});
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 3)), "rand");
    end
  endtask

`ifdef STACK_BOUNDS_CHECK_EN
  task automatic test_bounds();
    set_sp(BASE);
    do_op(2'b01, 16'h0, 16'h0, 0, "pop_at_base");
    set_sp(LIMIT);
    do_op(2'b00, 16'hA5A5, 16'h0, 0, "push_at_limit");
    do_op(2'b10, 16'h2000, 16'h0300, 0, "call_at_limit");
  endtask
`endif

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; op_data = 16'h0; pc_in = 16'h0;
    sp_load = 1'b0; sp_load_val = 16'h0; ack_waits = 0; m_sp = BASE; m_pop = 16'h0;
    test_reset();
    test_push();
    test_pop();
    test_call_ret();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
`ifdef STACK_BOUNDS_CHECK_EN
    test_bounds();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
